irq_ctrl8: RTL

IRQ_CTRL8 -- requirements
Module: irq_ctrl8

---
 rtl/irq_pkg.sv | 21 ++
 rtl/prio_enc8to3.sv | 23 ++
 rtl/irq_ctrl8.sv | 94 +++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the 8-source interrupt controller.
package irq_pkg;

  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  // One-hot decode of a source index, used to clear the acknowledged bit.
  function automatic logic [N_SRC-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [N_SRC-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_enc8to3.sv
// 8-to-3 priority encoder: bit 7 has highest priority, valid only when enabled.
module prio_enc8to3 (
  input  logic [7:0] Din,
  input  logic       EN,
  output logic [2:0] Y,
  output logic       valid
);

  // Scan upward so the highest set index is the last one written.
  always_comb begin
    Y     = 3'd0;
    valid = 1'b0;
    if (EN) begin
      for (int i = 0; i < 8; i++) begin
        if (Din[i]) begin
          Y     = i[2:0];
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/irq_ctrl8.sv
// Eight-source interrupt controller: captures requests into pending bits,
// presents the highest-priority enabled one and holds it until acknowledged.
module irq_ctrl8
  import irq_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] mask,
  input  logic             en,
  input  logic             int_ack,
  output logic             int_valid,
  output logic [ID_W-1:0]  int_id,
  output logic [N_SRC-1:0] pending
);

  state_t           state;
  logic [N_SRC-1:0] irq_d;
  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] clr_vec;
  logic [ID_W-1:0]  sel_id;
  logic             sel_valid;

  // Selection runs off registered pending bits only, so no input reaches an output combinationally.
  prio_enc8to3 u_prio (
    .Din   (pending & mask),
    .EN    (en),
    .Y     (sel_id),
    .valid (sel_valid)
  );

  // Capture condition per source; mask/en deliberately play no part here.
  always_comb begin
    set_vec = '0;
    if (EDGE_MODE != 0) set_vec = irq_in & ~irq_d;
    else                set_vec = irq_in;
  end

  // Acknowledge clears only the presented bit, and only while presenting.
  always_comb begin
    clr_vec = '0;
    if (state == PRESENT && int_ack) clr_vec = id_onehot(int_id);
  end

  // Input history and pending bits; a new set outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_d   <= '0;
      pending <= '0;
    end else begin
      irq_d   <= irq_in;
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

  // Presentation FSM with registered int_valid/int_id; no pre-emption while presenting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      int_valid <= 1'b0;
      int_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            int_id    <= sel_id;
            int_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (int_ack) begin
            int_valid <= 1'b0;
            state     <= GAP;
          end else if (!en) begin
            int_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        GAP: begin
          int_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          int_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
